// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and types for the CDB arbiter slice.
// Sizes of the ROB/CDB datapath and the requester index map.
package cdb_arbiter_pkg;

  localparam int CDB_N_REQ  = 3;
  localparam int CDB_DEPTH  = 2;
  localparam int CDB_ROB_W  = 4;
  localparam int CDB_DATA_W = 32;
  localparam int CDB_SRC_W  = 2;

  localparam logic [CDB_SRC_W-1:0] CDB_SRC_ALU  = 2'd0;
  localparam logic [CDB_SRC_W-1:0] CDB_SRC_LOAD = 2'd1;
  localparam logic [CDB_SRC_W-1:0] CDB_SRC_BR   = 2'd2;

  typedef struct packed {
    logic [CDB_ROB_W-1:0]  pos;
    logic [CDB_DATA_W-1:0] val;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-producer and broadcast signals of the CDB arbiter.
// master = execution units / ROB side, slave = the arbiter.
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;

  logic                             rdy;
  logic                             flush;
  logic [CDB_ROB_W-1:0]             rob_front;
  logic [CDB_N_REQ-1:0]             req_valid;
  logic [CDB_N_REQ*CDB_ROB_W-1:0]   req_pos;
  logic [CDB_N_REQ*CDB_DATA_W-1:0]  req_val;
  logic [CDB_N_REQ-1:0]             req_ready;
  logic                             cdb_valid;
  logic [CDB_ROB_W-1:0]             cdb_pos;
  logic [CDB_DATA_W-1:0]            cdb_val;
  logic [CDB_SRC_W-1:0]             cdb_src;

  modport master (
    output rdy, flush, rob_front, req_valid, req_pos, req_val,
    input  req_ready, cdb_valid, cdb_pos, cdb_val, cdb_src
  );

  modport slave (
    input  rdy, flush, rob_front, req_valid, req_pos, req_val,
    output req_ready, cdb_valid, cdb_pos, cdb_val, cdb_src
  );

endinterface

// File: rtl/cdb_req_fifo.sv
// Shallow per-requester result FIFO with synchronous clear.
// Pointers wrap naturally; count is one bit wider to tell full from empty.
module cdb_req_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the CDB between the ALU, load and branch result producers.
// Optional CDB_AGE_PRIO_EN switches round-robin to oldest-ROB-entry-first.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = CDB_DEPTH
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);

  localparam int ENTRY_W = $bits(cdb_entry_t);

  cdb_entry_t           head [CDB_N_REQ];
  logic [CDB_N_REQ-1:0] full;
  logic [CDB_N_REQ-1:0] empty;
  logic [CDB_N_REQ-1:0] push;
  logic [CDB_N_REQ-1:0] pop;
  logic [CDB_SRC_W-1:0] rr;
  logic [CDB_SRC_W-1:0] win;
  logic                 found;

  for (genvar g = 0; g < CDB_N_REQ; g++) begin : g_fifo
    cdb_entry_t din;
    assign din.pos = bus.req_pos[g*CDB_ROB_W +: CDB_ROB_W];
    assign din.val = bus.req_val[g*CDB_DATA_W +: CDB_DATA_W];

    cdb_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.flush),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (din),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // A full FIFO refuses input even when it is popped in the same cycle.
  assign bus.req_ready = ~full & {CDB_N_REQ{bus.rdy & ~bus.flush}};
  assign push          = bus.req_valid & bus.req_ready;

  always_comb begin
    found = 1'b0;
    win   = '0;
`ifdef CDB_AGE_PRIO_EN
    begin
      logic [CDB_ROB_W-1:0] age;
      logic [CDB_ROB_W-1:0] best_age;
      age      = '0;
      best_age = '0;
      for (int i = 0; i < CDB_N_REQ; i++) begin
        age = head[i].pos - bus.rob_front;
        if (!empty[i] && (!found || age < best_age)) begin
          found    = 1'b1;
          win      = CDB_SRC_W'(i);
          best_age = age;
        end
      end
    end
`else
    begin
      logic [CDB_SRC_W-1:0] idx;
      idx = '0;
      for (int k = 1; k <= CDB_N_REQ; k++) begin
        idx = CDB_SRC_W'((int'(rr) + k) % CDB_N_REQ);
        if (!found && !empty[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
`endif
  end

  always_comb begin
    pop = '0;
    if (bus.rdy && !bus.flush && found) pop[win] = 1'b1;
  end

  // Flush wins over the rdy stall because the ROB flushes regardless of rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr            <= CDB_SRC_W'(CDB_N_REQ - 1);
      bus.cdb_valid <= 1'b0;
      bus.cdb_pos   <= '0;
      bus.cdb_val   <= '0;
      bus.cdb_src   <= '0;
    end else if (bus.flush) begin
      rr            <= CDB_SRC_W'(CDB_N_REQ - 1);
      bus.cdb_valid <= 1'b0;
    end else if (bus.rdy) begin
      if (found) begin
        bus.cdb_valid <= 1'b1;
        bus.cdb_pos   <= head[win].pos;
        bus.cdb_val   <= head[win].val;
        bus.cdb_src   <= win;
        rr            <= win;
      end else begin
        bus.cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus random traffic
// compared against a queue-level model of the arbitration rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = CDB_N_REQ;
  localparam int D = CDB_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if bus ();
  cdb_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  cdb_entry_t      mq [N][D];
  int              msz [N];
  int              m_last;
  logic            e_valid;
  logic [3:0]      e_pos;
  logic [31:0]     e_val;
  logic [1:0]      e_src;
  logic [3:0]      cur_pos [N];
  logic [31:0]     cur_val [N];
  bit              rand_pos;
  int              compared = 0;
  int              mismatched = 0;
  int              order [3];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick();
    int best = -1;
`ifdef CDB_AGE_PRIO_EN
    int best_age = 1 << CDB_ROB_W;
    for (int i = 0; i < N; i++) begin
      if (msz[i] > 0) begin
        int age = ((int'(mq[i][0].pos) - int'(bus.rob_front)) % (1 << CDB_ROB_W)
                   + (1 << CDB_ROB_W)) % (1 << CDB_ROB_W);
        if (age < best_age) begin
          best     = i;
          best_age = age;
        end
      end
    end
`else
    for (int k = 1; k <= N; k++) begin
      int i = (m_last + k) % N;
      if (best < 0 && msz[i] > 0) best = i;
    end
`endif
    return best;
  endfunction

  task automatic run_cycle();
    logic [2:0] exp_ready;
    logic [2:0] acc;
    int w;
    for (int i = 0; i < N; i++) exp_ready[i] = bus.rdy && !bus.flush && (msz[i] != D);
    check_output("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    acc = bus.req_valid & exp_ready;
    if (bus.flush) begin
      for (int i = 0; i < N; i++) msz[i] = 0;
      e_valid = 1'b0;
      m_last  = N - 1;
    end else if (bus.rdy) begin
      w = model_pick();
      if (w >= 0) begin
        e_valid = 1'b1;
        e_pos   = mq[w][0].pos;
        e_val   = mq[w][0].val;
        e_src   = 2'(w);
        m_last  = w;
        for (int j = 0; j < D - 1; j++) mq[w][j] = mq[w][j+1];
        msz[w]--;
      end else begin
        e_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          mq[i][msz[i]].pos = cur_pos[i];
          mq[i][msz[i]].val = cur_val[i];
          msz[i]++;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        cur_pos[i] = rand_pos ? 4'($urandom) : cur_pos[i] + 4'd1;
        cur_val[i] = $urandom;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_output("cdb_valid", 32'(bus.cdb_valid), 32'(e_valid));
    check_output("cdb_pos",   32'(bus.cdb_pos),   32'(e_pos));
    check_output("cdb_val",   bus.cdb_val,        e_val);
    check_output("cdb_src",   32'(bus.cdb_src),   32'(e_src));
  endtask

  task automatic apply_stimulus(input logic rdy, input logic flush, input logic [2:0] valid);
    bus.rdy       = rdy;
    bus.flush     = flush;
    bus.req_valid = valid;
    for (int i = 0; i < N; i++) begin
      bus.req_pos[i*CDB_ROB_W +: CDB_ROB_W]   = cur_pos[i];
      bus.req_val[i*CDB_DATA_W +: CDB_DATA_W] = cur_val[i];
    end
    #1;
    run_cycle();
  endtask

  initial begin
    rst           = 1'b1;
    rand_pos      = 1'b0;
    bus.rdy       = 1'b1;
    bus.flush     = 1'b0;
    bus.rob_front = '0;
    bus.req_valid = '0;
    bus.req_pos   = '0;
    bus.req_val   = '0;
    for (int i = 0; i < N; i++) begin
      msz[i]     = 0;
      cur_pos[i] = '0;
      cur_val[i] = '0;
    end
    m_last  = N - 1;
    e_valid = 1'b0;
    e_pos   = '0;
    e_val   = '0;
    e_src   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    check_output("rst_valid", 32'(bus.cdb_valid), 32'd0);
    check_output("rst_pos",   32'(bus.cdb_pos),   32'd0);
    check_output("rst_val",   bus.cdb_val,        32'd0);
    check_output("rst_src",   32'(bus.cdb_src),   32'd0);
    check_output("rst_ready", 32'(bus.req_ready), 32'b111);

    $display("[TB] single ALU push");
    cur_pos[0] = 4'd3;
    cur_val[0] = 32'h11;
    apply_stimulus(1'b1, 1'b0, 3'b001);
    check_output("single_lat0", 32'(bus.cdb_valid), 32'd0);
    apply_stimulus(1'b1, 1'b0, 3'b000);
    check_output("single_valid", 32'(bus.cdb_valid), 32'd1);
    check_output("single_pos",   32'(bus.cdb_pos),   32'd3);
    check_output("single_val",   bus.cdb_val,        32'h11);
    check_output("single_src",   32'(bus.cdb_src),   32'(CDB_SRC_ALU));
    apply_stimulus(1'b1, 1'b0, 3'b000);
    check_output("single_drop", 32'(bus.cdb_valid), 32'd0);

    $display("[TB] continuous pushes from all requesters");
    cur_pos[0] = 4'd1;
    cur_pos[1] = 4'd2;
    cur_pos[2] = 4'd3;
    repeat (12) apply_stimulus(1'b1, 1'b0, 3'b111);

    $display("[TB] flush with full FIFOs");
    apply_stimulus(1'b1, 1'b1, 3'b111);
    check_output("flush_valid", 32'(bus.cdb_valid), 32'd0);
    repeat (3) apply_stimulus(1'b1, 1'b0, 3'b000);

    $display("[TB] rdy stall while streaming");
    cur_pos[0] = 4'd5;
    repeat (2) apply_stimulus(1'b1, 1'b0, 3'b111);
    repeat (3) apply_stimulus(1'b0, 1'b0, 3'b111);
    repeat (8) apply_stimulus(1'b1, 1'b0, 3'b000);

    $display("[TB] age ordering");
`ifdef CDB_AGE_PRIO_EN
    order = '{2, 1, 0};
`else
    order = '{0, 1, 2};
`endif
    apply_stimulus(1'b1, 1'b1, 3'b000);
    bus.rob_front = 4'd14;
    cur_pos[0] = 4'd1;
    cur_pos[1] = 4'd15;
    cur_pos[2] = 4'd14;
    apply_stimulus(1'b1, 1'b0, 3'b111);
    for (int k = 0; k < 3; k++) begin
      apply_stimulus(1'b1, 1'b0, 3'b000);
      check_output("age_order", 32'(bus.cdb_src), 32'(order[k]));
    end

    $display("[TB] random traffic");
    rand_pos = 1'b1;
    for (int c = 0; c < 400; c++) begin
      bus.rob_front = 4'($urandom);
      apply_stimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single ROB write-back/broadcast bus (CDB) between N_REQ result producers: ALU RS, LSB load, branch unit.
- Each producer pushes {ROB pos, value} into a private shallow FIFO. One head per cycle is granted and driven as a registered CDB beat to ROB, RS and LSB.
- Sits between the execution units and the ROB's update port. Honours the global rdy stall and the ROB's jump_wrong flush.

Parameters:
N_REQ, 3, number of requesters (index 0 = ALU, 1 = load, 2 = branch)
DEPTH, 2, entries per requester FIFO (power of two, >=2)
ROB_W, 4, ROB index width (16-entry ROB)
DATA_W, 32, result width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low = full stall
flush  in  1  jump_wrong from ROB; drop all pending results
rob_front  in  ROB_W  current ROB head index; used only with CDB_AGE_PRIO_EN
req_valid  in  N_REQ  per-requester result valid
req_pos  in  N_REQ*ROB_W  flattened ROB positions; requester i at [i*ROB_W +: ROB_W]
req_val  in  N_REQ*DATA_W  flattened results
req_ready  out  N_REQ  per-requester accept
cdb_valid  out  1  broadcast valid (registered)
cdb_pos  out  ROB_W  broadcast ROB position (registered)
cdb_val  out  DATA_W  broadcast value (registered)
cdb_src  out  2  index of granted requester (registered)

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. On reset: FIFOs empty, RR pointer = N_REQ-1 (requester 0 wins first), cdb_valid=0, cdb_pos=0, cdb_val=0, cdb_src=0.
- req_ready[i] = rdy && !flush && count[i] != DEPTH. Derived from registered count only; no dependence on req_valid.
- Enqueue when req_valid[i] && req_ready[i]. No enqueue/dequeue pass-through when full: a full FIFO refuses input even if it is popped the same cycle.
- Arbitration each rdy cycle: candidates = non-empty FIFOs. Default policy is round-robin: search from RR+1 upward, modulo N_REQ. Winner's head is popped. cdb_* <= head fields, cdb_src <= winner, cdb_valid <= 1. RR <= winner.
- No candidate: cdb_valid <= 0. cdb_pos, cdb_val and cdb_src hold their last values.
- Latency: result accepted at edge E is on the bus at the earliest in the cycle after edge E+1. There is no empty-FIFO bypass.
- Exactly one beat per cycle. Throughput is 1 result/cycle aggregate.
- Simultaneous enqueue and pop on the same FIFO (not full): count unchanged, order preserved.
- Wrap-around: FIFO rd/wr pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- flush (registered-cycle semantics, priority over everything except rst): all FIFOs emptied, cdb_valid <= 0, RR reset to N_REQ-1, inputs that cycle ignored (req_ready already 0).
- rdy=0: all state and all outputs held, including cdb_valid. No enqueue, no pop.
- flush with rdy=0: flush still takes effect, because the ROB flushes regardless of rdy.

Optional Feature:
CDB_AGE_PRIO_EN
- Defined: policy is oldest-first.
  - age_i = (head_pos_i - rob_front) mod 2^ROB_W, computed ROB_W-bit unsigned.
  - The candidate with the smallest age wins. Ties go to the lower index.
  - RR pointer still updated but unused.
- Undefined: pure round-robin as above. rob_front is unused and may be left unconnected.

Decomposition:
- Shared package/defines: ROB_W, DATA_W, requester index constants (CDB_SRC_ALU=0, CDB_SRC_LOAD=1, CDB_SRC_BR=2).
- One sub-module, cdb_req_fifo: parameterised DEPTH/width FIFO with push, pop, clear, full, empty, head. Instantiated N_REQ times via generate.
- Arbiter/select logic stays in cdb_arbiter.

Test Plan:
- Reset then single ALU push {pos=3, val=0x11}: req_ready=3'b111 throughout; cdb_valid high in the 2nd cycle after acceptance with pos=3, val=0x11, src=0, then low.
- All three requesters push continuously (pos 1, 2, 3 …), RR build: grants cycle src 0,1,2,0,1,2; no beat lost or duplicated; one beat/cycle.
- Load FIFO fills (DEPTH=2) while its pushes are starved: req_ready[1] drops to 0 at count=2 and rises the cycle after a pop; payload order preserved.
- flush asserted with 2 entries in each FIFO: next cycle cdb_valid=0, all FIFOs empty, req_ready=0 during flush cycle then 3'b111; no stale pos broadcast afterwards.
- rdy held low 3 cycles with cdb_valid=1 (pos=5): outputs frozen, no pops, req_ready=0; streaming resumes unchanged when rdy=1.
- With CDB_AGE_PRIO_EN, rob_front=14, heads ALU pos=1, load pos=15, branch pos=14: grant order branch, load, ALU (ages 0, 1, 3). Without the macro: ALU, load, branch.
